alu2bit_arbiter: RTL and testbench
==================================

ALU2BIT_ARBITER -- requirements
Module: alu2bit_arbiter

Interface
REQ-001 Parameter CNT_W, default 8, width of the grant counters in REQ-024.
REQ-002 Port CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port REQ  input  2  per-requester request; bit i belongs to requester i.
REQ-005 Ports A0, B0, OP0  input  2 each  requester 0 operands and opcode.
REQ-006 Ports A1, B1, OP1  input  2 each  requester 1 operands and opcode.
REQ-007 Port GNT  output  2  one-hot grant, high from the operand-latch edge through the DONE cycle.
REQ-008 Port DONE  output  2  one-cycle completion pulse to the granted requester.
REQ-009 Port RESULT  output  2  registered ALU result; valid while DONE is high; held until the next DONE.
REQ-010 Port BUSY  output  1  high in any state other than IDLE.

Function
REQ-011 The block SHALL share one 2-bit ALU between two requesters, one operation at a time.
REQ-012 Opcodes SHALL be: 00 AND, 01 OR, 10 ADD mod 4, 11 SUB mod 4 (A-B, two's-complement wrap); no carry or borrow output.
REQ-013 FSM states SHALL be IDLE, EXEC and RESP, with a registered state.
REQ-014 IDLE with REQ!=0: on the edge, latch the winner's A/B/OP, set GNT one-hot, and go to EXEC.
REQ-015 IDLE with REQ==0: remain in IDLE; GNT=00, DONE=00.
REQ-016 EXEC: on the edge, register the ALU output into RESULT, set DONE of the granted requester, and go to RESP.
REQ-017 RESP: DONE high for exactly this cycle; on the edge clear DONE and GNT and go to IDLE.
REQ-018 Latency SHALL be 2 edges from REQ sampled to DONE high; peak throughput is one operation per 3 cycles.
REQ-019 Arbitration SHALL be round-robin: if both REQ bits are high in IDLE, the requester not most recently granted wins.
REQ-020 Only the winner's operands are used; the loser stays pending and wins the next IDLE cycle if it is still requesting.
REQ-021 Operand or REQ changes after the latch edge SHALL NOT affect the operation in flight; a dropped REQ still receives DONE.
REQ-022 A requester whose REQ is still high in the IDLE cycle after its DONE is re-arbitrated as a new request.

Reset
REQ-023 RST_N low SHALL immediately, asynchronously, force: state IDLE, GNT=00, DONE=00, RESULT=00, BUSY=0, last-granted pointer set so that requester 0 wins the first tie; an in-flight operation is discarded with no DONE.

Configuration
REQ-024 With macro ALU2BIT_ARB_STATS_EN defined, outputs GNT_CNT0 and GNT_CNT1 (CNT_W bits each) SHALL count grants per requester, increment on the latch edge, saturate at all-ones, and reset to 0.
REQ-025 Without ALU2BIT_ARB_STATS_EN, the GNT_CNT ports and their counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-026 Shared package alu2bit_pkg SHALL hold the opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB) and the FSM state encoding (IDLE, EXEC, RESP).
REQ-027 The datapath SHALL be one instance of the existing alu2bit_top, wired BUTTONS={A_latched,B_latched}, SWITCHES=OP_latched, LEDS=ALU output; the arbiter contains no other arithmetic.

Verification
REQ-028 Reset, then REQ=01, A0=3, B0=2, OP0=10 -> GNT=01 after edge 1; DONE=01 and RESULT=01 after edge 2; idle after edge 3.
REQ-029 REQ=11, A0=1, B0=3, OP0=00, A1=0, B1=1, OP1=11, both held -> first DONE=01 with RESULT=01; next DONE=10 with RESULT=11.
REQ-030 Latch A1=2, B1=1, OP1=01, then change A1 to 0 and drop REQ during EXEC -> DONE=10 still pulses with RESULT=11.
REQ-031 Assert RST_N=0 in EXEC -> GNT, DONE, RESULT and BUSY go to 0 without waiting for a clock edge; no DONE follows after release.
REQ-032 Keep REQ=10 high continuously -> DONE=10 every 3rd cycle; BUSY low exactly one cycle between operations.
REQ-033 With ALU2BIT_ARB_STATS_EN and CNT_W=2, issue 5 grants to requester 0 -> GNT_CNT0 saturates at 3 and GNT_CNT1 stays 0.

Source files
------------

// File: rtl/alu2bit_pkg.sv
// Shared opcode constants, FSM encoding and the round-robin pick helper
// used by the two-requester ALU arbiter.
package alu2bit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // One-hot winner; on a tie the requester not granted last time wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_idx);
        logic [1:0] win;
        win = 2'b00;
        if (req == 2'b11) begin
            win = last_idx ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
        return win;
    endfunction

endpackage

// File: rtl/alu2bit_top.sv
// Combinational 2-bit ALU: BUTTONS = {A, B}, SWITCHES = opcode, LEDS = result.
// ADD/SUB wrap modulo 4; no carry or borrow is produced.
module alu2bit_top
    import alu2bit_pkg::*;
(
    input  logic [3:0] BUTTONS,
    input  logic [1:0] SWITCHES,
    output logic [1:0] LEDS
);

    logic [1:0] a;
    logic [1:0] b;

    assign a = BUTTONS[3:2];
    assign b = BUTTONS[1:0];

    always_comb begin
        LEDS = 2'b00;
        case (SWITCHES)
            OP_AND:  LEDS = a & b;
            OP_OR:   LEDS = a | b;
            OP_ADD:  LEDS = a + b;
            OP_SUB:  LEDS = a - b;
            default: LEDS = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu2bit_arbiter.sv
// Round-robin arbiter sharing one alu2bit_top between two requesters
// (IDLE -> EXEC -> RESP). Optional per-requester grant counters: ALU2BIT_ARB_STATS_EN.
module alu2bit_arbiter
    import alu2bit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       REQ,
    input  logic [1:0]       A0,
    input  logic [1:0]       B0,
    input  logic [1:0]       OP0,
    input  logic [1:0]       A1,
    input  logic [1:0]       B1,
    input  logic [1:0]       OP1,
    output logic [1:0]       GNT,
    output logic [1:0]       DONE,
    output logic [1:0]       RESULT,
    output logic             BUSY
`ifdef ALU2BIT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] GNT_CNT0,
    output logic [CNT_W-1:0] GNT_CNT1
`endif
);

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [1:0] result_q, result_d;
    logic       last_q, last_d;
    logic [1:0] a_q, b_q, op_q;
    logic [1:0] win;
    logic       lat_en;
    logic [1:0] alu_y;

    alu2bit_top u_alu (
        .BUTTONS  ({a_q, b_q}),
        .SWITCHES (op_q),
        .LEDS     (alu_y)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        result_d = result_q;
        last_d   = last_q;
        lat_en   = 1'b0;
        win      = 2'b00;
        case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                if (REQ != 2'b00) begin
                    win     = rr_pick(REQ, last_q);
                    gnt_d   = win;
                    last_d  = win[1];
                    lat_en  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_y;
                done_d   = gnt_q;
                state_d  = RESP;
            end
            RESP: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // last_q resets to requester 1 so requester 0 takes the first tie.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= 2'b00;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            last_q   <= last_d;
        end
    end

    // Operands are captured once; later input changes cannot disturb EXEC.
    always_ff @(posedge CLK) begin
        if (lat_en) begin
            a_q  <= win[1] ? A1  : A0;
            b_q  <= win[1] ? B1  : B0;
            op_q <= win[1] ? OP1 : OP0;
        end
    end

    assign GNT    = gnt_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign BUSY   = (state_q != IDLE);

`ifdef ALU2BIT_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (lat_en) begin
            if (win[0] && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + CNT_ONE;
            if (win[1] && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + CNT_ONE;
        end
    end

    assign GNT_CNT0 = cnt0_q;
    assign GNT_CNT1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu2bit_arbiter.sv
// Self-checking bench for alu2bit_arbiter: vector table plus hand sequences,
// with a DONE/RESULT scoreboard queue checked by a negedge monitor.
module tb_alu2bit_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] REQ = 2'b00;
    logic [1:0] A0 = 2'b00, B0 = 2'b00, OP0 = 2'b00;
    logic [1:0] A1 = 2'b00, B1 = 2'b00, OP1 = 2'b00;
    logic [1:0] GNT, DONE, RESULT;
    logic       BUSY;
`ifdef ALU2BIT_ARB_STATS_EN
    logic [1:0] cnt0, cnt1;
`endif

    alu2bit_arbiter #(.CNT_W(2)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .REQ    (REQ),
        .A0     (A0),
        .B0     (B0),
        .OP0    (OP0),
        .A1     (A1),
        .B1     (B1),
        .OP1    (OP1),
        .GNT    (GNT),
        .DONE   (DONE),
        .RESULT (RESULT),
        .BUSY   (BUSY)
`ifdef ALU2BIT_ARB_STATS_EN
        ,
        .GNT_CNT0 (cnt0),
        .GNT_CNT1 (cnt1)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] done;
        logic [1:0] result;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] exp_result;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE != 2'b00) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got DONE=%b expected none at %0t", DONE, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_done", DONE, e.done);
                chk("sb_result", RESULT, e.result);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Single-requester operation from IDLE; the other requester carries decoy operands.
    task automatic run_op(input vec_t v);
        exp_t e;
        if (v.req[0]) begin
            A0 = v.a; B0 = v.b; OP0 = v.op;
            A1 = ~v.a; B1 = ~v.b; OP1 = ~v.op;
        end else begin
            A1 = v.a; B1 = v.b; OP1 = v.op;
            A0 = ~v.a; B0 = ~v.b; OP0 = ~v.op;
        end
        REQ = v.req;
        tick();
        chk("latch_gnt", GNT, v.req);
        chk("latch_busy", BUSY, 1);
        e.done = v.req; e.result = v.exp_result;
        sb.push_back(e);
        REQ = 2'b00;
        tick();
        chk("resp_done", DONE, v.req);
        tick();
        chk("idle_busy", BUSY, 0);
        chk("idle_gnt", GNT, 0);
        chk("held_result", RESULT, v.exp_result);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        REQ = 2'b00;
        #1;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    vec_t vecs[8];
    exp_t e;

    initial begin
        vecs[0] = '{2'b01, 2'd3, 2'd2, 2'b10, 2'd1};
        vecs[1] = '{2'b01, 2'd2, 2'd3, 2'b00, 2'd2};
        vecs[2] = '{2'b10, 2'd1, 2'd2, 2'b01, 2'd3};
        vecs[3] = '{2'b10, 2'd0, 2'd1, 2'b11, 2'd3};
        vecs[4] = '{2'b01, 2'd1, 2'd3, 2'b11, 2'd2};
        vecs[5] = '{2'b10, 2'd3, 2'd3, 2'b10, 2'd2};
        vecs[6] = '{2'b01, 2'd3, 2'd3, 2'b00, 2'd3};
        vecs[7] = '{2'b10, 2'd0, 2'd0, 2'b01, 2'd0};

        #2;
        chk("rst_gnt", GNT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_result", RESULT, 0);
        chk("rst_busy", BUSY, 0);
        do_reset();

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Tie: requester 0 wins first after reset, then requester 1.
        do_reset();
        A0 = 2'd1; B0 = 2'd3; OP0 = 2'b00;
        A1 = 2'd0; B1 = 2'd1; OP1 = 2'b11;
        REQ = 2'b11;
        tick();
        chk("tie_gnt0", GNT, 2'b01);
        e.done = 2'b01; e.result = 2'd1; sb.push_back(e);
        tick();
        chk("tie_done0", DONE, 2'b01);
        tick();
        chk("tie_idle_busy", BUSY, 0);
        tick();
        chk("tie_gnt1", GNT, 2'b10);
        e.done = 2'b10; e.result = 2'd3; sb.push_back(e);
        REQ = 2'b00;
        tick();
        chk("tie_done1", DONE, 2'b10);
        chk("tie_result1", RESULT, 2'd3);
        tick();

        // Operand change and REQ drop after the latch edge.
        A1 = 2'd2; B1 = 2'd1; OP1 = 2'b01;
        REQ = 2'b10;
        tick();
        A1 = 2'd0;
        REQ = 2'b00;
        e.done = 2'b10; e.result = 2'd3; sb.push_back(e);
        tick();
        chk("inflight_done", DONE, 2'b10);
        chk("inflight_result", RESULT, 2'd3);
        tick();

        // Asynchronous reset in EXEC: outputs clear without a clock edge.
        A0 = 2'd1; B0 = 2'd1; OP0 = 2'b10;
        REQ = 2'b01;
        tick();
        chk("pre_rst_busy", BUSY, 1);
        chk("pre_rst_result", RESULT, 2'd3);
        RST_N = 1'b0;
        REQ = 2'b00;
        #1;
        chk("arst_gnt", GNT, 0);
        chk("arst_done", DONE, 0);
        chk("arst_result", RESULT, 0);
        chk("arst_busy", BUSY, 0);
        tick();
        RST_N = 1'b1;
        repeat (4) tick();
        chk("arst_no_done", DONE, 0);

        // Continuous REQ=10: DONE every third cycle, one idle cycle between.
        A1 = 2'd1; B1 = 2'd1; OP1 = 2'b10;
        REQ = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("cont_gnt", GNT, 2'b10);
            chk("cont_busy_exec", BUSY, 1);
            e.done = 2'b10; e.result = 2'd2; sb.push_back(e);
            tick();
            chk("cont_done", DONE, 2'b10);
            tick();
            chk("cont_busy_idle", BUSY, 0);
            chk("cont_done_low", DONE, 0);
            if (k == 2) REQ = 2'b00;
        end
        tick();
        chk("cont_stays_idle", BUSY, 0);

`ifdef ALU2BIT_ARB_STATS_EN
        do_reset();
        chk("cnt0_rst", cnt0, 0);
        for (int k = 0; k < 5; k++) begin
            A0 = 2'd2; B0 = 2'd1; OP0 = 2'b01;
            REQ = 2'b01;
            tick();
            e.done = 2'b01; e.result = 2'd3; sb.push_back(e);
            REQ = 2'b00;
            tick();
            tick();
        end
        chk("cnt0_sat", cnt0, 2'd3);
        chk("cnt1_zero", cnt1, 2'd0);
`endif

        repeat (2) tick();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
